// File: rtl/arm_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : arm_ctrl_sequencer
//  Brief    : Multi-cycle microstate sequencer for the ARM datapath. Walks
//             fetch/decode, dispatches to the encoder's execute state, stalls
//             on memory handshakes with a timeout, retires and halts.
//  Revision : 1.0 - initial release
// ============================================================================
module arm_ctrl_sequencer #(
    parameter int STATE_W     = 7,
    parameter int FETCH_STATE = 1,
    parameter int MIN_EXEC    = 4,
    parameter int HALT_STATE  = 126,
    parameter int FAULT_STATE = 127,
    parameter int MOC_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] enc_state,
    input  logic               cond_pass,
    input  logic [1:0]         uc_next,
    input  logic               uc_mem,
    input  logic               moc,
    input  logic               halt_req,
    output logic [STATE_W-1:0] state,
    output logic               mem_busy,
    output logic               halted,
    output logic               fault,
    output logic [15:0]        instr_count
);

    // Microcode next-state select field from the control ROM
    typedef enum logic [1:0] {
        UC_INC      = 2'b00,
        UC_DISPATCH = 2'b01,
        UC_FETCH    = 2'b10,
        UC_HOLD     = 2'b11
    } ucNext_e;

    localparam logic [STATE_W-1:0] c_resetState = '0;
    localparam logic [STATE_W-1:0] c_fetchState = STATE_W'(FETCH_STATE);
    localparam logic [STATE_W-1:0] c_minExec    = STATE_W'(MIN_EXEC);
    localparam logic [STATE_W-1:0] c_haltState  = STATE_W'(HALT_STATE);
    localparam logic [STATE_W-1:0] c_faultState = STATE_W'(FAULT_STATE);
    localparam logic [TO_W-1:0]    c_timeoutLast = TO_W'(MOC_TIMEOUT - 1);

    logic [STATE_W-1:0] w_nextState;
    logic [TO_W-1:0]    w_nextTimeout;
    logic [TO_W-1:0]    r_timeoutCnt;
    logic               w_retire;
    logic               w_stalled;
    logic [STATE_W:0]   w_incState;
    ucNext_e            w_ucSel;

    // moc only matters while the current microstate is waiting on memory
    assign w_stalled  = uc_mem & ~moc;
    assign mem_busy   = w_stalled;
    // One extra bit so the increment past the top code is still visible
    assign w_incState = {1'b0, state} + (STATE_W+1)'(1);
    assign w_ucSel    = ucNext_e'(uc_next);

    // Next-state selection in priority order: reset state, fault, halt,
    // timeout, stall, then the microcode next-state field
    always_comb begin
        w_nextState   = state;
        w_nextTimeout = '0;
        w_retire      = 1'b0;
        if (state == c_resetState) begin
            w_nextState = c_fetchState;
        end else if (state == c_faultState) begin
            w_nextState = c_faultState;
        end else if (state == c_haltState) begin
            w_nextState = halt_req ? c_haltState : c_fetchState;
        end else if (w_stalled) begin
            if (r_timeoutCnt == c_timeoutLast) begin
                w_nextState = c_faultState;
            end else begin
                w_nextTimeout = r_timeoutCnt + 1'b1;
            end
        end else begin
            case (w_ucSel)
                UC_INC: begin
                    if (w_incState >= {1'b0, c_haltState}) begin
                        w_nextState = c_faultState;
                    end else begin
                        w_nextState = w_incState[STATE_W-1:0];
                    end
                end
                UC_DISPATCH: begin
                    if (!cond_pass) begin
                        w_retire = 1'b1;
                    end else if (enc_state < c_minExec || enc_state >= c_haltState) begin
                        w_nextState = c_faultState;
                    end else begin
                        w_nextState = enc_state;
                    end
                end
                UC_FETCH: begin
                    w_retire = 1'b1;
                end
                default: begin
                    w_nextState = state;
                end
            endcase
        end
        // A retiring instruction lands on fetch, or parks in halt if requested
        if (w_retire) begin
            w_nextState = halt_req ? c_haltState : c_fetchState;
        end
    end

    // State, timeout counter, status flags and retire counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= c_resetState;
            r_timeoutCnt <= '0;
            halted       <= 1'b0;
            fault        <= 1'b0;
            instr_count  <= '0;
        end else begin
            state        <= w_nextState;
            r_timeoutCnt <= w_nextTimeout;
            halted       <= (w_nextState == c_haltState);
            fault        <= (w_nextState == c_faultState);
            if (w_retire) begin
                instr_count <= instr_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arm_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arm_ctrl_sequencer
//  Brief    : Self-checking bench for arm_ctrl_sequencer. A behavioural model
//             pushes expected results into a scoreboard queue as stimulus is
//             driven; they are popped and compared after each clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arm_ctrl_sequencer;

    logic        clk;
    logic        reset;
    logic [6:0]  encState;
    logic        condPass;
    logic [1:0]  ucNext;
    logic        ucMem;
    logic        moc;
    logic        haltReq;
    logic [6:0]  state;
    logic        memBusy;
    logic        halted;
    logic        fault;
    logic [15:0] instrCount;

    typedef struct {
        logic [6:0]  st;
        logic        h;
        logic        f;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic [6:0]  mState;
    logic [15:0] mCount;
    int          mTo;
    int          errors = 0;
    int          checks = 0;

    arm_ctrl_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .enc_state   (encState),
        .cond_pass   (condPass),
        .uc_next     (ucNext),
        .uc_mem      (ucMem),
        .moc         (moc),
        .halt_req    (haltReq),
        .state       (state),
        .mem_busy    (memBusy),
        .halted      (halted),
        .fault       (fault),
        .instr_count (instrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge
    task automatic step(input string tag);
        logic [6:0]  ns;
        logic [15:0] nc;
        int          nto;
        bit          retire;
        exp_t        e;
        ns = mState; nc = mCount; nto = 0; retire = 0;
        if (mState == 7'd0) ns = 7'd1;
        else if (mState == 7'd127) ns = 7'd127;
        else if (mState == 7'd126) ns = haltReq ? 7'd126 : 7'd1;
        else if (ucMem && !moc) begin
            if (mTo == 14) ns = 7'd127;
            else nto = mTo + 1;
        end else begin
            case (ucNext)
                2'd0: ns = (int'(mState) + 1 >= 126) ? 7'd127 : mState + 7'd1;
                2'd1: begin
                    if (!condPass) retire = 1;
                    else if (int'(encState) < 4 || int'(encState) >= 126) ns = 7'd127;
                    else ns = encState;
                end
                2'd2: retire = 1;
                default: ns = mState;
            endcase
        end
        if (retire) begin
            nc = mCount + 16'd1;
            ns = haltReq ? 7'd126 : 7'd1;
        end
        e.st = ns; e.h = (ns == 7'd126); e.f = (ns == 7'd127); e.cnt = nc;
        sb.push_back(e);
        #1;
        checkVal({tag, "_membusy"}, 32'(memBusy), 32'(ucMem && !moc));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checkVal({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            checkVal({tag, "_state"}, 32'(state), 32'(e.st));
            checkVal({tag, "_halted"}, 32'(halted), 32'(e.h));
            checkVal({tag, "_fault"}, 32'(fault), 32'(e.f));
            checkVal({tag, "_count"}, 32'(instrCount), 32'(e.cnt));
        end
        mState = ns; mCount = nc; mTo = nto;
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges, held two cycles
    task automatic doReset(input string tag);
        reset = 1'b1;
        #1;
        checkVal({tag, "_rst_state"}, 32'(state), 32'd0);
        checkVal({tag, "_rst_count"}, 32'(instrCount), 32'd0);
        checkVal({tag, "_rst_flags"}, 32'({halted, fault}), 32'd0);
        sb.delete();
        mState = 7'd0; mCount = 16'd0; mTo = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVal({tag, "_rst_hold"}, 32'(state), 32'd0);
        reset = 1'b0;
    endtask

    task automatic drive(input logic [1:0] un, input logic cp, input logic [6:0] es,
                         input logic um, input logic mc, input logic hr);
        ucNext = un; condPass = cp; encState = es; ucMem = um; moc = mc; haltReq = hr;
    endtask

    initial begin
        reset = 1'b1;
        drive(2'd0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
        mState = 7'd0; mCount = 16'd0; mTo = 0;
        @(negedge clk);

        // T1: reset, fetch, increment, dispatch
        doReset("t1");
        step("t1_fetch");
        checkVal("t1_fetch_direct", 32'(state), 32'd1);
        step("t1_inc");
        checkVal("t1_inc_direct", 32'(state), 32'd2);
        drive(2'd1, 1'b1, 7'd4, 1'b0, 1'b0, 1'b0);
        step("t1_dispatch");
        checkVal("t1_dispatch_direct", 32'(state), 32'd4);

        // T2: failed condition retires; fetch select retires
        drive(2'd1, 1'b0, 7'd11, 1'b0, 1'b0, 1'b0);
        step("t2_condfail");
        checkVal("t2_condfail_direct", 32'(instrCount), 32'd1);
        drive(2'd0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
        step("t2_inc");
        drive(2'd1, 1'b1, 7'd13, 1'b0, 1'b0, 1'b0);
        step("t2_disp13");
        drive(2'd2, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
        step("t2_retire");
        checkVal("t2_retire_direct", 32'({state, instrCount}), 32'({7'd1, 16'd2}));

        // T3: short stall then release; counter must clear afterwards
        drive(2'd0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
        step("t3_inc");
        drive(2'd0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("t3_stall");
        checkVal("t3_stall_direct", 32'({state, memBusy}), 32'({7'd2, 1'b1}));
        moc = 1'b1;
        step("t3_moc");
        checkVal("t3_moc_direct", 32'(state), 32'd3);
        moc = 1'b0;
        for (int i = 0; i < 14; i++) step("t3_restall");
        checkVal("t3_noto_direct", 32'({state, fault}), 32'({7'd3, 1'b0}));
        moc = 1'b1;
        step("t3_release");

        // T4: stall timeout on the 15th edge, fault is sticky
        drive(2'd0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) step("t4_stall");
        checkVal("t4_before_to", 32'({state, fault}), 32'({7'd4, 1'b0}));
        step("t4_timeout");
        checkVal("t4_fault_direct", 32'({state, fault}), 32'({7'd127, 1'b1}));
        for (int i = 0; i < 4; i++) begin
            drive(2'(i), 1'b1, 7'd20, 1'b1, 1'b1, 1'(i));
            step("t4_sticky");
        end
        doReset("t4");

        // T5: halt at retire, hold while requested, resume on release
        drive(2'd0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
        step("t5_fetch");
        step("t5_inc");
        drive(2'd2, 1'b0, 7'd0, 1'b0, 1'b0, 1'b1);
        step("t5_halt");
        checkVal("t5_halt_direct", 32'({state, halted, instrCount}), 32'({7'd126, 1'b1, 16'd1}));
        drive(2'd1, 1'b1, 7'd50, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step("t5_hold");
        drive(2'd0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
        step("t5_resume");
        checkVal("t5_resume_direct", 32'({state, halted}), 32'({7'd1, 1'b0}));

        // Top legal dispatch, then increment past it faults
        drive(2'd1, 1'b1, 7'd125, 1'b0, 1'b0, 1'b0);
        step("edge_disp125");
        drive(2'd0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
        step("edge_incfault");
        checkVal("edge_incfault_direct", 32'(state), 32'd127);
        doReset("edge");

        // T6: illegal dispatch targets
        drive(2'd0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
        step("t6_fetch");
        drive(2'd1, 1'b1, 7'd2, 1'b0, 1'b0, 1'b0);
        step("t6_ill2");
        checkVal("t6_ill2_direct", 32'(fault), 32'd1);
        doReset("t6a");
        drive(2'd0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
        step("t6_fetchb");
        drive(2'd1, 1'b1, 7'd126, 1'b0, 1'b0, 1'b0);
        step("t6_ill126");
        checkVal("t6_ill126_direct", 32'(fault), 32'd1);
        doReset("t6b");

        // T6: retire something, stall, then async reset between edges
        drive(2'd0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
        step("t6_fetchc");
        drive(2'd2, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
        step("t6_retire");
        drive(2'd0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("t6_stall");
        #2;
        doReset("t6_midstall");

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            if (mState == 7'd127) doReset("rnd");
            ucNext   = 2'($urandom_range(0, 3));
            condPass = 1'($urandom_range(0, 1));
            encState = ($urandom_range(0, 15) == 0) ? 7'($urandom_range(0, 127))
                                                    : 7'($urandom_range(4, 125));
            ucMem    = ($urandom_range(0, 3) == 0);
            moc      = 1'($urandom_range(0, 1));
            haltReq  = ($urandom_range(0, 7) == 0);
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
